jk_register: RTL and testbench

Parametrised WIDTH-bit JK register, the multi-bit successor to the single-bit JK flip-flop. Each bit follows JK semantics from per-bit `j`/`k` vectors. Three further modes (up-count, down-count, parallel load) reuse the same state register, with a terminal-count flag. Used as a general-purpose state/counter element in sequential lab designs.

---
 rtl/jk_pkg.sv | 23 ++
 rtl/jk_next_bit.sv | 22 ++
 rtl/jk_register.sv | 82 ++++++++
 tb/tb_jk_register.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types for the JK register: the operation-mode encoding and the
// per-bit JK action encoding ({j,k} read as a 2-bit code).
package jk_pkg;

  typedef enum logic [1:0] {
    JK_MODE_JK   = 2'b00,
    JK_MODE_UP   = 2'b01,
    JK_MODE_DOWN = 2'b10,
    JK_MODE_LOAD = 2'b11
  } jk_mode_e;

  typedef enum logic [1:0] {
    JK_ACT_HOLD   = 2'b00,
    JK_ACT_CLEAR  = 2'b01,
    JK_ACT_SET    = 2'b10,
    JK_ACT_TOGGLE = 2'b11
  } jk_act_e;

  function automatic jk_act_e jk_action(input logic j, input logic k);
    return jk_act_e'({j, k});
  endfunction

endpackage

// File: rtl/jk_next_bit.sv
// Combinational next-state function of one JK bit.
module jk_next_bit
  import jk_pkg::*;
(
  input  logic j,
  input  logic k,
  input  logic q,
  output logic q_next
);

  always_comb begin
    q_next = q;
    case (jk_action(j, k))
      JK_ACT_HOLD:   q_next = q;
      JK_ACT_CLEAR:  q_next = 1'b0;
      JK_ACT_SET:    q_next = 1'b1;
      JK_ACT_TOGGLE: q_next = ~q;
      default:       q_next = q;
    endcase
  end

endmodule

// File: rtl/jk_register.sv
// WIDTH-bit JK register with up/down count and parallel load modes.
// Define JK_SATURATE_EN to make UP/DOWN hold at the ends instead of wrapping.
module jk_register
  import jk_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] qb_q, qb_d;
  logic [WIDTH-1:0] jk_next;
  jk_mode_e         mode_e;
  logic             all_ones, all_zeros;

  assign mode_e    = jk_mode_e'(mode);
  assign all_ones  = &state_q;
  assign all_zeros = ~|state_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_next_bit u_bit (
      .j      (j[i]),
      .k      (k[i]),
      .q      (state_q[i]),
      .q_next (jk_next[i])
    );
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (mode_e)
        JK_MODE_JK:   state_d = jk_next;
`ifdef JK_SATURATE_EN
        JK_MODE_UP:   state_d = all_ones  ? state_q : state_q + WIDTH'(1);
        JK_MODE_DOWN: state_d = all_zeros ? state_q : state_q - WIDTH'(1);
`else
        JK_MODE_UP:   state_d = state_q + WIDTH'(1);
        JK_MODE_DOWN: state_d = state_q - WIDTH'(1);
`endif
        JK_MODE_LOAD: state_d = j;
        default:      state_d = state_q;
      endcase
    end
  end

  // qb is registered from the same next value so it can never disagree with q
  assign qb_d = ~state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      qb_q    <= ~INIT;
    end else begin
      state_q <= state_d;
      qb_q    <= qb_d;
    end
  end

  always_comb begin
    tc = 1'b0;
    case (mode_e)
      JK_MODE_UP:   tc = all_ones;
      JK_MODE_DOWN: tc = all_zeros;
      default:      tc = 1'b0;
    endcase
  end

  assign q  = state_q;
  assign qb = qb_q;

endmodule

// File: tb/tb_jk_register.sv
// Self-checking bench for jk_register (WIDTH=8, INIT=8'hA5): directed vector
// table, a combinational tc sequence, then random stimulus against a model.
module tb_jk_register;

  localparam logic [7:0] INIT_V = 8'hA5;

  logic       clk = 1'b0;
  logic       reset, en;
  logic [1:0] mode;
  logic [7:0] j, k, q, qb;
  logic       tc;

  int errors = 0;
  int checks = 0;

  jk_register #(.WIDTH(8), .INIT(INIT_V)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .j     (j),
    .k     (k),
    .q     (q),
    .qb    (qb),
    .tc    (tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] eq;
    logic       etc;
  } vec_t;

  vec_t tv[$];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [7:0] jj, input logic [7:0] kk);
    reset = r; en = e; mode = m; j = jj; k = kk;
    @(posedge clk);
    #1;
  endtask

  // Reference model: characteristic equation for JK, integer arithmetic for counting.
  function automatic logic [7:0] model_next(input logic [7:0] cur, input logic r,
      input logic e, input logic [1:0] m, input logic [7:0] jj, input logic [7:0] kk);
    int v;
    if (r) return INIT_V;
    if (!e) return cur;
    v = int'(cur);
    case (m)
      2'd0: return (jj & ~cur) | (~kk & cur);
`ifdef JK_SATURATE_EN
      2'd1: return (v == 255) ? cur : 8'(v + 1);
      2'd2: return (v == 0)   ? cur : 8'(v - 1);
`else
      2'd1: return 8'((v + 1) % 256);
      2'd2: return 8'((v + 255) % 256);
`endif
      default: return jj;
    endcase
  endfunction

  function automatic logic model_tc(input logic [7:0] cur, input logic [1:0] m);
    return (m == 2'd1 && cur == 8'hFF) || (m == 2'd2 && cur == 8'h00);
  endfunction

  initial begin
    logic [7:0] mq;
    logic       r, e;
    logic [1:0] m;
    logic [7:0] jj, kk;

    reset = 1'b0; en = 1'b0; mode = 2'd0; j = '0; k = '0;

    tv.push_back('{1'b1, 1'b1, 2'd1, 8'h00, 8'h00, 8'hA5, 1'b0}); // reset
    tv.push_back('{1'b1, 1'b0, 2'd1, 8'h00, 8'h00, 8'hA5, 1'b0}); // reset beats en=0/UP
    tv.push_back('{1'b0, 1'b1, 2'd3, 8'h0F, 8'hFF, 8'h0F, 1'b0});
    tv.push_back('{1'b0, 1'b1, 2'd0, 8'hCC, 8'hAA, 8'hC5, 1'b0}); // JK mix of all four actions
    tv.push_back('{1'b0, 1'b1, 2'd3, 8'hFD, 8'h00, 8'hFD, 1'b0});
    tv.push_back('{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'hFE, 1'b0});
    tv.push_back('{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'hFF, 1'b1});
`ifdef JK_SATURATE_EN
    tv.push_back('{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'hFF, 1'b1});
    tv.push_back('{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'hFF, 1'b1});
`else
    tv.push_back('{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'h00, 1'b0});
    tv.push_back('{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'h01, 1'b0});
`endif
    tv.push_back('{1'b0, 1'b1, 2'd3, 8'h01, 8'h00, 8'h01, 1'b0});
    tv.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'h00, 1'b1});
    tv.push_back('{1'b0, 1'b0, 2'd2, 8'h00, 8'h00, 8'h00, 1'b1}); // en=0 holds
`ifdef JK_SATURATE_EN
    tv.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'h00, 1'b1});
    tv.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'h00, 1'b1});
`else
    tv.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'hFF, 1'b0});
    tv.push_back('{1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'hFE, 1'b0});
`endif
    tv.push_back('{1'b0, 1'b1, 2'd3, 8'h3C, 8'hFF, 8'h3C, 1'b0});
    tv.push_back('{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'h3D, 1'b0});
    tv.push_back('{1'b0, 1'b1, 2'd3, 8'hFF, 8'h00, 8'hFF, 1'b0});
    tv.push_back('{1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'hFF, 1'b0}); // JK hold at FF: tc=0
    tv.push_back('{1'b0, 1'b1, 2'd3, 8'h40, 8'h00, 8'h40, 1'b0});
    tv.push_back('{1'b1, 1'b1, 2'd1, 8'h00, 8'h00, 8'hA5, 1'b0}); // reset mid-count
    tv.push_back('{1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'hA6, 1'b0});

    repeat (2) @(posedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst, tv[i].en, tv[i].mode, tv[i].j, tv[i].k);
      chk8($sformatf("vec%0d_q", i), q, tv[i].eq);
      chk8($sformatf("vec%0d_qb", i), qb, ~tv[i].eq);
      chk1($sformatf("vec%0d_tc", i), tc, tv[i].etc);
    end

    // tc reacts to a mode change with no clock edge
    step(1'b0, 1'b1, 2'd3, 8'h00, 8'h00);
    en = 1'b0; mode = 2'd2; #1;
    chk1("tc_comb_down_zero", tc, 1'b1);
    mode = 2'd1; #1;
    chk1("tc_comb_up_zero", tc, 1'b0);
    mode = 2'd3; j = 8'hFF; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; mode = 2'd1; #1;
    chk1("tc_comb_up_ones_en0", tc, 1'b1);
    mode = 2'd0; #1;
    chk1("tc_comb_jk_ones", tc, 1'b0);
    chk8("hold_en0_q", q, 8'hFF);

    // Randomized phase against the reference model
    mq = 8'hFF;
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 3) != 0);
      m  = 2'($urandom_range(0, 3));
      jj = 8'($urandom);
      kk = 8'($urandom);
      if ($urandom_range(0, 7) == 0) jj = 8'hFF;
      mq = model_next(mq, r, e, m, jj, kk);
      step(r, e, m, jj, kk);
      chk8($sformatf("rnd%0d_q", n), q, mq);
      chk8($sformatf("rnd%0d_qb", n), qb, ~mq);
      chk1($sformatf("rnd%0d_tc", n), tc, model_tc(mq, m));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
